out_port_bank: RTL and testbench

- Parametrised successor to the single 8-bit `display` output latch on the CPU top level.
- Provides NUM_PORTS independent output channels, each with a DEPTH-entry first-word-fall-through (FWFT) FIFO toward external consumers.
- Each channel also keeps a "last written" hold register, which preserves the old display semantics.
- Sits between the controller/ALU (write side) and chip output pins or peripherals (ready/valid read side), and asserts stall back to the controller when the targeted channel cannot accept a write.

---
 rtl/out_port_pkg.sv | 24 ++
 rtl/out_fifo.sv | 72 +++++++
 rtl/out_port_bank.sv | 64 ++++++
 tb/tb_out_port_bank.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/out_port_pkg.sv
// Shared defaults and width helpers for the output port bank.
package out_port_pkg;

    localparam int unsigned DEF_DATA_W    = 8;
    localparam int unsigned DEF_NUM_PORTS = 2;
    localparam int unsigned DEF_DEPTH     = 4;

    // Channel select is at least one bit wide even for a single channel.
    function automatic int unsigned sel_w(input int unsigned num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned DEF_PTR_W = ptr_w(DEF_DEPTH);
    localparam int unsigned DEF_CNT_W = cnt_w(DEF_DEPTH);

endpackage

// File: rtl/out_fifo.sv
// Single-channel first-word-fall-through FIFO with sticky overflow flag.
module out_fifo
    import out_port_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] data,
    input  logic              ready,
    input  logic              clr_ovf,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic              full,
    output logic              accepted,
    output logic              dropped,
    output logic              overflow
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              pop;

    always_comb begin
        valid    = (count != '0);
        full     = (count == CNT_MAX);
        pop      = valid & ready;
        // A full channel can still take a word when its head leaves this cycle.
        accepted = push & (~full | pop);
        dropped  = push & full & ~pop;
        head     = mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (accepted) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (accepted && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !accepted) begin
                count <= count - CNT_W'(1);
            end
            if (dropped) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/out_port_bank.sv
// Bank of independent output channels, each a FWFT FIFO plus a last-written hold register.
module out_port_bank
    import out_port_pkg::*;
#(
    parameter  int unsigned DATA_W    = DEF_DATA_W,
    parameter  int unsigned NUM_PORTS = DEF_NUM_PORTS,
    parameter  int unsigned DEPTH     = DEF_DEPTH,
    localparam int unsigned SEL_W     = sel_w(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [SEL_W-1:0]            wr_sel,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        stall,
    output logic [NUM_PORTS-1:0]        full,
    output logic [NUM_PORTS-1:0]        out_valid,
    input  logic [NUM_PORTS-1:0]        out_ready,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS*DATA_W-1:0] last,
    output logic [NUM_PORTS-1:0]        overflow,
    input  logic [NUM_PORTS-1:0]        clr_ovf
);

    logic                 sel_ok;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] accepted;
    logic [NUM_PORTS-1:0] dropped;

    assign sel_ok = (32'(wr_sel) < NUM_PORTS);
    // Only the selected channel can drop, so any drop is exactly the stall condition.
    assign stall  = |dropped;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_ch
        assign push[i] = wr_en & sel_ok & (wr_sel == SEL_W'(i));

        out_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push[i]),
            .data     (wr_data),
            .ready    (out_ready[i]),
            .clr_ovf  (clr_ovf[i]),
            .head     (out_data[i*DATA_W +: DATA_W]),
            .valid    (out_valid[i]),
            .full     (full[i]),
            .accepted (accepted[i]),
            .dropped  (dropped[i]),
            .overflow (overflow[i])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                last[i*DATA_W +: DATA_W] <= '0;
            end else if (accepted[i]) begin
                last[i*DATA_W +: DATA_W] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_out_port_bank.sv
// Randomised and directed bench for out_port_bank with a queue-based reference model and scoreboard.
module tb_out_port_bank;

    localparam int DW  = 8;
    localparam int NP  = 3;
    localparam int DEP = 4;
    localparam int SW  = 2;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             wr_en;
    logic [SW-1:0]    wr_sel;
    logic [DW-1:0]    wr_data;
    logic             stall;
    logic [NP-1:0]    full;
    logic [NP-1:0]    out_valid;
    logic [NP-1:0]    out_ready;
    logic [NP*DW-1:0] out_data;
    logic [NP*DW-1:0] last;
    logic [NP-1:0]    overflow;
    logic [NP-1:0]    clr_ovf;

    out_port_bank #(
        .DATA_W    (DW),
        .NUM_PORTS (NP),
        .DEPTH     (DEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .stall     (stall),
        .full      (full),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .last      (last),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q [NP][$];
    logic [DW-1:0] sb_q    [NP][$];
    logic [DW-1:0] exp_last[NP];
    logic [NP-1:0] exp_ovf;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: compares each word the DUT hands to a ready consumer against the scoreboard.
    always @(negedge clk) begin
        #3;
        if (rst_n) begin
            for (int i = 0; i < NP; i++) begin
                chk($sformatf("valid%0d", i), 32'(out_valid[i]), 32'(sb_q[i].size() != 0));
                if (out_valid[i] && out_ready[i] && sb_q[i].size() != 0) begin
                    chk($sformatf("data%0d", i), 32'(out_data[i*DW +: DW]), 32'(sb_q[i].pop_front()));
                end
            end
        end
    end

    task automatic cycle(input logic we, input logic [SW-1:0] sel, input logic [DW-1:0] d,
                         input logic [NP-1:0] rdy, input logic [NP-1:0] clr);
        logic [NP-1:0] pop;
        logic          ok;
        logic          exp_stall;
        @(negedge clk);
        wr_en = we; wr_sel = sel; wr_data = d; out_ready = rdy; clr_ovf = clr;
        #1;
        ok = (int'(sel) < NP);
        for (int i = 0; i < NP; i++) pop[i] = rdy[i] && (model_q[i].size() != 0);
        exp_stall = 1'b0;
        if (we && ok) exp_stall = (model_q[sel].size() == DEP) && !pop[sel];
        chk("stall", 32'(stall), 32'(exp_stall));
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("full%0d", i), 32'(full[i]), 32'(model_q[i].size() == DEP));
            chk($sformatf("ovf%0d", i), 32'(overflow[i]), 32'(exp_ovf[i]));
            chk($sformatf("last%0d", i), 32'(last[i*DW +: DW]), 32'(exp_last[i]));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (pop[i]) void'(model_q[i].pop_front());
            if (clr[i]) exp_ovf[i] = 1'b0;
        end
        if (we && ok) begin
            if (exp_stall) begin
                exp_ovf[sel] = 1'b1;
            end else begin
                model_q[sel].push_back(d);
                sb_q[sel].push_back(d);
                exp_last[sel] = d;
            end
        end
    endtask

    task automatic idle(input logic [NP-1:0] rdy);
        cycle(1'b0, '0, '0, rdy, '0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_full"}, 32'(full), 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'h0);
        chk({tag, "_last"}, 32'(last), 32'h0);
        chk({tag, "_data"}, 32'(out_data), 32'h0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            model_q[i].delete();
            sb_q[i].delete();
            exp_last[i] = '0;
        end
        exp_ovf = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        wr_en = 1'b0; out_ready = '0; clr_ovf = '0;
        #2 rst_n = 1'b0;
        #2;
        check_cleared("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        wr_en = 1'b0; wr_sel = '0; wr_data = '0; out_ready = '0; clr_ovf = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_cleared("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single write to ch0, ch1 untouched.
        cycle(1'b1, 2'd0, 8'h5A, 3'b000, 3'b000);
        idle(3'b000);
        chk("ch0_head", 32'(out_data[0 +: DW]), 32'h5A);
        chk("ch1_idle", 32'(out_valid[1]), 32'h0);
        idle(3'b001);

        // Fill ch1, overflow on the fifth word, then clear the flag.
        for (int k = 1; k <= 4; k++) cycle(1'b1, 2'd1, DW'(k), 3'b000, 3'b000);
        cycle(1'b1, 2'd1, 8'h05, 3'b000, 3'b000);
        idle(3'b000);
        chk("ovf1_set", 32'(overflow[1]), 32'h1);
        cycle(1'b0, 2'd0, 8'h00, 3'b000, 3'b010);
        idle(3'b000);

        // Write into full ch1 while its head is consumed, then drain.
        cycle(1'b1, 2'd1, 8'h06, 3'b010, 3'b000);
        repeat (5) idle(3'b010);

        // Eight words through ch0 against a half-rate consumer; pointers wrap.
        for (int k = 0; k < 8; k++) cycle(1'b1, 2'd0, DW'(8'h10 + k), (k % 2 == 1) ? 3'b001 : 3'b000, 3'b000);
        repeat (6) idle(3'b001);

        // Out-of-range select is ignored.
        cycle(1'b1, 2'd3, 8'hFF, 3'b000, 3'b000);
        idle(3'b000);

        // Mid-operation reset with buffered data and a set overflow flag.
        for (int k = 0; k < 3; k++) cycle(1'b1, 2'd0, DW'(8'hA0 + k), 3'b000, 3'b000);
        for (int k = 0; k < 5; k++) cycle(1'b1, 2'd1, DW'(8'hB0 + k), 3'b000, 3'b000);
        pulse_reset();
        cycle(1'b1, 2'd0, 8'h33, 3'b000, 3'b000);
        idle(3'b001);
        idle(3'b001);

        // Random traffic across all channels, including invalid selects.
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)), DW'($urandom),
                  NP'($urandom), ($urandom_range(0, 7) == 0) ? NP'($urandom) : '0);
        end
        repeat (DEP + 2) idle('1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
